// File: rtl/su_dcache_responder.sv
// Data-cache responder: grants requests after a programmable hold time, serves stores into a
// small byte-writable memory and answers loads through a tag-phase handshake.
module su_dcache_responder #(
    parameter int unsigned GNT_DELAY = 1,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] address_index_i,
    input  logic [21:0] address_tag_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic        kill_req_i,
    input  logic        tag_valid_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [15:0] wr_count_o,
    output logic        store_mem_resp_o
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_TAG, RESP} state_e;

    state_e        state_q, state_d;
    logic [2:0]    gcnt_q, gcnt_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [AW-1:0] req_widx;
    logic [31:0]   mem_q [MEM_WORDS];
    logic [31:0]   rdata_q;
    logic [15:0]   wr_count_q;
    logic          store_resp_q;
    logic          gnt;
    logic          store_gnt;
    logic          rdata_en;
    logic          unused_addr;

    // Only the word-select bits address the memory; the rest of the address is don't-care.
    assign req_widx    = address_index_i[2 +: AW];
    assign unused_addr = ^{address_tag_i, address_index_i[1:0], address_index_i[11:2+AW]};

    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        widx_d   = widx_q;
        gnt      = 1'b0;
        rdata_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!data_req_i) begin
                    gcnt_d = 3'd0;
                end else if (gcnt_q == 3'(GNT_DELAY)) begin
                    gnt    = 1'b1;
                    gcnt_d = 3'd0;
                    if (!data_we_i) begin
                        state_d = WAIT_TAG;
                        widx_d  = req_widx;
                    end
                end else begin
                    gcnt_d = gcnt_q + 3'd1;
                end
            end
            WAIT_TAG: begin
                gcnt_d = 3'd0;
                if (kill_req_i) begin
                    state_d = IDLE;
                end else if (tag_valid_i) begin
                    rdata_en = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                gcnt_d  = 3'd0;
                state_d = IDLE;
            end
            default: begin
                gcnt_d  = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign store_gnt = gnt & data_we_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            gcnt_q       <= 3'd0;
            widx_q       <= '0;
            rdata_q      <= 32'd0;
            wr_count_q   <= 16'd0;
            store_resp_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gcnt_q       <= gcnt_d;
            widx_q       <= widx_d;
            store_resp_q <= store_gnt;
            if (rdata_en) begin
                rdata_q <= mem_q[widx_q];
            end
            if (store_gnt && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < int'(MEM_WORDS); w++) begin
                mem_q[w] <= 32'd0;
            end
        end else if (store_gnt) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[req_widx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign data_gnt_o       = gnt;
    assign data_rvalid_o    = (state_q == RESP);
    assign data_rdata_o     = rdata_q;
    assign wr_count_o       = wr_count_q;
    assign store_mem_resp_o = store_resp_q;

endmodule

// File: tb/tb_su_dcache_responder.sv
// Bench for su_dcache_responder: directed and random loads/stores on a GNT_DELAY=1 instance,
// plus a long store burst on a GNT_DELAY=0 instance for counter saturation.
module tb_su_dcache_responder;

    localparam int unsigned GD = 1;
    localparam int unsigned MW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, kill, tagv;
    logic [11:0] index;
    logic [21:0] tag;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt, rvalid, sresp;
    logic [31:0] rdata;
    logic [15:0] wcnt;

    logic        z_rst, z_req, z_we, z_kill, z_tagv;
    logic [11:0] z_index;
    logic [21:0] z_tag;
    logic [31:0] z_wdata;
    logic [3:0]  z_be;
    logic        z_gnt, z_rvalid, z_sresp;
    logic [31:0] z_rdata;
    logic [15:0] z_wcnt;

    su_dcache_responder #(.GNT_DELAY(GD), .MEM_WORDS(MW)) dut (
        .clk_i(clk), .rst_i(rst), .address_index_i(index), .address_tag_i(tag),
        .data_wdata_i(wdata), .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .kill_req_i(kill), .tag_valid_i(tagv), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_rdata_o(rdata), .wr_count_o(wcnt), .store_mem_resp_o(sresp)
    );

    su_dcache_responder #(.GNT_DELAY(0), .MEM_WORDS(MW)) dut0 (
        .clk_i(clk), .rst_i(z_rst), .address_index_i(z_index), .address_tag_i(z_tag),
        .data_wdata_i(z_wdata), .data_req_i(z_req), .data_we_i(z_we), .data_be_i(z_be),
        .kill_req_i(z_kill), .tag_valid_i(z_tagv), .data_gnt_o(z_gnt),
        .data_rvalid_o(z_rvalid), .data_rdata_o(z_rdata), .wr_count_o(z_wcnt),
        .store_mem_resp_o(z_sresp)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain word array, store counter and last returned load value.
    logic [31:0] mdl_mem [MW];
    int          mdl_wc;
    logic [31:0] mdl_rdata;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < int'(MW); w++) mdl_mem[w] = 32'd0;
        mdl_wc    = 0;
        mdl_rdata = 32'd0;
    endtask

    function automatic int word_of(input logic [11:0] idx_v);
        return (int'(idx_v) >> 2) % int'(MW);
    endfunction

    task automatic wait_grant(input string name);
        for (int k = 0; k <= int'(GD); k++) begin
            #1;
            check(name, 32'(gnt), 32'(k == int'(GD)));
            if (k < int'(GD)) @(negedge clk);
        end
    endtask

    task automatic do_store(input logic [11:0] idx_v, input logic [31:0] d, input logic [3:0] b);
        int w;
        @(negedge clk);
        req = 1'b1; we = 1'b1; index = idx_v; tag = 22'($urandom); wdata = d; be = b;
        wait_grant("st_gnt");
        @(negedge clk);
        req = 1'b0; we = 1'b0; wdata = $urandom; be = 4'($urandom);
        w = word_of(idx_v);
        for (int i = 0; i < 4; i++) if (b[i]) mdl_mem[w][8*i +: 8] = d[8*i +: 8];
        if (mdl_wc < 65535) mdl_wc++;
        #1;
        check("st_resp", 32'(sresp), 32'd1);
        check("wr_count", 32'(wcnt), 32'(mdl_wc));
        check("st_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("st_resp_off", 32'(sresp), 32'd0);
    endtask

    task automatic do_load(input logic [11:0] idx_v, input int tag_wait, input logic do_kill);
        int w;
        w = word_of(idx_v);
        @(negedge clk);
        req = 1'b1; we = 1'b0; index = idx_v; be = 4'($urandom);
        wait_grant("ld_gnt");
        @(negedge clk);
        index = 12'($urandom);
        for (int k = 0; k < tag_wait; k++) begin
            req = 1'b1;
            #1;
            check("wt_gnt", 32'(gnt), 32'd0);
            check("wt_rvalid", 32'(rvalid), 32'd0);
            @(negedge clk);
        end
        req = 1'b0; tagv = 1'b1; kill = do_kill;
        #1;
        check("tag_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        tagv = 1'b0; kill = 1'($urandom);
        if (!do_kill) mdl_rdata = mdl_mem[w];
        #1;
        check("ld_rvalid", 32'(rvalid), 32'(!do_kill));
        check("ld_rdata", rdata, mdl_rdata);
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("ld_rvalid_off", 32'(rvalid), 32'd0);
        check("ld_rdata_hold", rdata, mdl_rdata);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; kill = 1'b0; tagv = 1'b0;
        index = '0; tag = '0; wdata = '0; be = '0;
        z_rst = 1'b1; z_req = 1'b0; z_we = 1'b0; z_kill = 1'b0; z_tagv = 1'b0;
        z_index = '0; z_tag = '0; z_wdata = 32'hA5A5_5A5A; z_be = 4'hF;
        model_reset();
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wcnt", 32'(wcnt), 32'd0);
        check("rst_sresp", 32'(sresp), 32'd0);
        @(negedge clk);
        rst = 1'b0; z_rst = 1'b0;

        do_store(12'h004, 32'hDEADBEEF, 4'hF);
        check("first_wcnt", 32'(wcnt), 32'd1);
        do_load(12'h004, 0, 1'b0);
        check("deadbeef", rdata, 32'hDEADBEEF);
        do_store(12'h000, 32'h11223344, 4'b0101);
        do_load(12'h000, 1, 1'b0);
        check("be_0101", rdata, 32'h00220044);
        do_load(12'h004, 2, 1'b1);
        do_store(12'h008, 32'hCAFEF00D, 4'b0000);
        do_load(12'hFEB, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 1) == 0)
                do_store(12'($urandom), $urandom, 4'($urandom));
            else
                do_load(12'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
        end

        // Reset while a load waits for its tag phase.
        @(negedge clk);
        req = 1'b1; we = 1'b0; index = 12'h004;
        wait_grant("rw_gnt");
        @(negedge clk);
        req = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("rw_gnt0", 32'(gnt), 32'd0);
        check("rw_rvalid0", 32'(rvalid), 32'd0);
        check("rw_rdata0", rdata, 32'd0);
        check("rw_wcnt0", 32'(wcnt), 32'd0);
        check("rw_sresp0", 32'(sresp), 32'd0);
        tagv = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tagv = 1'b0;
        #1;
        check("rw_no_rvalid", 32'(rvalid), 32'd0);
        do_load(12'h004, 0, 1'b0);
        check("rw_mem_zero", rdata, 32'd0);
        do_load(12'h000, 0, 1'b0);

        // Reset right after a store grant drops the pending store pulse.
        @(negedge clk);
        req = 1'b1; we = 1'b1; index = 12'h010; wdata = 32'h0BAD_0BAD; be = 4'hF;
        wait_grant("rs_gnt");
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("rs_sresp", 32'(sresp), 32'd0);
        check("rs_wcnt", 32'(wcnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_load(12'h010, 0, 1'b0);

        // Zero-delay instance: continuous stores, grant every cycle, counter saturates.
        @(negedge clk);
        z_req = 1'b1; z_we = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            #1;
            check("z_gnt", 32'(z_gnt), 32'd1);
            @(negedge clk);
            check("z_wcnt", 32'(z_wcnt), 32'((i < 65535) ? i : 65535));
            check("z_sresp", 32'(z_sresp), 32'd1);
        end
        z_req = 1'b0; z_we = 1'b0;
        #1;
        check("z_gnt_off", 32'(z_gnt), 32'd0);
        @(negedge clk);
        check("z_sresp_off", 32'(z_sresp), 32'd0);
        check("z_wcnt_sat", 32'(z_wcnt), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
